// File: rtl/demux_pack.sv
// -----------------------------------------------------------------------------
// demux_pack
//
// Packs a serial stream of single bits into an 8-bit word. Each accepted bit
// is steered to a lane picked by S[3:1]. S[0] is ignored, so select pairs
// 0/1 .. 14/15 map to lanes 0 .. 7. The word is released downstream once all
// eight lanes are written.
//
// States:
//   FILL : in_ready=1, out_valid=0, bits are accepted into Y / lane_mask.
//   HOLD : in_ready=0, out_valid=1, Y / lane_mask are frozen until out_ready.
//
// Optional feature (macro DEMUX_PACK_TIMEOUT_EN):
//   When the macro is defined, a partly filled word is force-released after
//   FLUSH_TIMEOUT consecutive idle FILL cycles. Unwritten lanes read as 0.
//   When the macro is undefined there is no counter, and a word is released
//   only when all eight lanes are written.
//
// Parameters:
//   FLUSH_TIMEOUT : idle cycles before a partial word is released (1..255)
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  upstream bit available
//   in_ready   out  1  block accepts a bit this cycle (FILL)
//   S          in   4  lane select, lane = S[3:1]
//   D          in   1  data bit for the selected lane
//   out_valid  out  1  assembled word available (HOLD)
//   out_ready  in   1  downstream consumes the word
//   Y          out  8  assembled word, Y[k] = last bit written to lane k
//   lane_mask  out  8  bit k set once lane k is written in the current word
//   dup_err    out  1  one-cycle pulse after a write to an already-written lane
// -----------------------------------------------------------------------------
module demux_pack #(
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] S,
    input  logic       D,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Y,
    output logic [7:0] lane_mask,
    output logic       dup_err
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [7:0] y_next;
    logic [7:0] mask_next;
    logic       dup_next;
    logic [2:0] lane;
    logic [7:0] lane_bit;
    logic       accept;

    // S[0] does not take part in lane selection.
    logic unused_s0;
    assign unused_s0 = S[0];

    assign lane      = S[3:1];
    assign lane_bit  = 8'b1 << lane;
    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

`ifdef DEMUX_PACK_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(FLUSH_TIMEOUT - 1);

    logic [7:0] idle_cnt, idle_cnt_next;
`else
    // The flush parameter has no effect when the timeout is compiled out.
    logic [7:0] unused_flush_timeout;
    assign unused_flush_timeout = 8'(FLUSH_TIMEOUT);
`endif

    // Next-state and next-data logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_next = state;
        y_next     = Y;
        mask_next  = lane_mask;
        dup_next   = 1'b0;
`ifdef DEMUX_PACK_TIMEOUT_EN
        idle_cnt_next = idle_cnt;
`endif

        case (state)
            FILL: begin
                if (accept) begin
                    y_next[lane] = D;
                    mask_next    = lane_mask | lane_bit;
                    dup_next     = lane_mask[lane];
`ifdef DEMUX_PACK_TIMEOUT_EN
                    idle_cnt_next = 8'd0;
`endif
                    if (mask_next == 8'hFF) begin
                        state_next = HOLD;
                    end
                end
`ifdef DEMUX_PACK_TIMEOUT_EN
                // Idle cycles only count once something has been written.
                else if (lane_mask != 8'h00) begin
                    if (idle_cnt == TIMEOUT_LAST) begin
                        state_next    = HOLD;
                        idle_cnt_next = 8'd0;
                    end else begin
                        idle_cnt_next = idle_cnt + 8'd1;
                    end
                end
`endif
            end

            HOLD: begin
`ifdef DEMUX_PACK_TIMEOUT_EN
                idle_cnt_next = 8'd0;
`endif
                if (out_ready) begin
                    y_next     = 8'h00;
                    mask_next  = 8'h00;
                    state_next = FILL;
                end
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data registers are reset as well as the state, because a
        // partial or held word must not survive a reset.
        if (rst) begin
            state     <= FILL;
            Y         <= 8'h00;
            lane_mask <= 8'h00;
            dup_err   <= 1'b0;
`ifdef DEMUX_PACK_TIMEOUT_EN
            idle_cnt  <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // values from before the edge, independent of statement order.
            state     <= state_next;
            Y         <= y_next;
            lane_mask <= mask_next;
            dup_err   <= dup_next;
`ifdef DEMUX_PACK_TIMEOUT_EN
            idle_cnt  <= idle_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_demux_pack.sv
// -----------------------------------------------------------------------------
// tb_demux_pack
//
// Directed bench for demux_pack. The expected words are pushed to a queue
// when the stimulus is driven. They are popped and compared when the DUT
// raises out_valid.
// -----------------------------------------------------------------------------
module tb_demux_pack;

    localparam int FLUSH_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] S;
    logic       D;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Y;
    logic [7:0] lane_mask;
    logic       dup_err;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] mask;
    } word_t;

    word_t sb_q[$];

    int compared   = 0;
    int mismatched = 0;

    demux_pack #(.FLUSH_TIMEOUT(FLUSH_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .lane_mask (lane_mask),
        .dup_err   (dup_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One accepted write; the accept happens on the next rising edge.
    task automatic write(input logic [3:0] sel, input logic d);
        in_valid = 1'b1;
        S        = sel;
        D        = d;
        tick();
    endtask

    // Wait (bounded) for a word, compare it with the scoreboard, then release it.
    task automatic drain(input string tag);
        word_t exp;
        int    waited;
        waited = 0;
        while (!out_valid && waited < 200) begin
            tick();
            waited++;
        end
        check({tag, "_out_valid"}, {7'd0, out_valid}, 8'h01);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h00, 8'h01);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_Y"}, Y, exp.y);
            check({tag, "_mask"}, lane_mask, exp.mask);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_clr_Y"}, Y, 8'h00);
        check({tag, "_clr_mask"}, lane_mask, 8'h00);
        check({tag, "_clr_in_ready"}, {7'd0, in_ready}, 8'h01);
        check({tag, "_clr_out_valid"}, {7'd0, out_valid}, 8'h00);
    endtask

    initial begin
        logic [7:0] pat;
        logic       seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S         = 4'd0;
        D         = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_Y", Y, 8'h00);
        check("rst_mask", lane_mask, 8'h00);
        check("rst_out_valid", {7'd0, out_valid}, 8'h00);
        check("rst_dup", {7'd0, dup_err}, 8'h00);
        rst = 1'b0;
        tick();
        check("rst_in_ready", {7'd0, in_ready}, 8'h01);

        // Full fill, even selects. D=1,0,1,1,0,0,1,0 for lanes 0..7 gives 8'h4D.
        pat = 8'h4D;
        sb_q.push_back('{y: 8'h4D, mask: 8'hFF});
        for (int i = 0; i < 8; i++) begin
            write(4'(2 * i), pat[i]);
            check($sformatf("fill_dup_%0d", i), {7'd0, dup_err}, 8'h00);
            check($sformatf("fill_ov_%0d", i), {7'd0, out_valid}, (i == 7) ? 8'h01 : 8'h00);
        end
        in_valid = 1'b0;
        check("fill_in_ready_low", {7'd0, in_ready}, 8'h00);
        drain("fill");

        // Odd selects with backpressure; inputs in HOLD must be ignored.
        sb_q.push_back('{y: 8'hFF, mask: 8'hFF});
        for (int i = 0; i < 8; i++) begin
            write(4'(2 * i + 1), 1'b1);
        end
        in_valid = 1'b1;
        S        = 4'd0;
        D        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_ov_%0d", i), {7'd0, out_valid}, 8'h01);
            check($sformatf("bp_ir_%0d", i), {7'd0, in_ready}, 8'h00);
            check($sformatf("bp_Y_%0d", i), Y, 8'hFF);
        end
        in_valid = 1'b0;
        drain("bp");

        // Duplicate lane: S=4 then S=5 both hit lane 2.
        write(4'd4, 1'b1);
        check("dup_first", {7'd0, dup_err}, 8'h00);
        write(4'd5, 1'b0);
        in_valid = 1'b0;
        check("dup_pulse", {7'd0, dup_err}, 8'h01);
        check("dup_Y", Y, 8'h00);
        check("dup_mask", lane_mask, 8'h04);
        tick();
        check("dup_pulse_end", {7'd0, dup_err}, 8'h00);

        // Reset mid-fill: add lanes 0,1,3,4 -> 5 lanes written, then reset.
        write(4'd0, 1'b1);
        write(4'd2, 1'b1);
        write(4'd6, 1'b1);
        write(4'd8, 1'b1);
        in_valid = 1'b0;
        check("mid_mask", lane_mask, 8'h1F);
        check("mid_Y", Y, 8'h1B);
        rst = 1'b1;
        #1;
        check("mid_rst_Y", Y, 8'h00);
        check("mid_rst_mask", lane_mask, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("mid_post_ov", {7'd0, out_valid}, 8'h00);
        check("mid_post_ir", {7'd0, in_ready}, 8'h01);
        check("mid_post_mask", lane_mask, 8'h00);

        // Fresh full fill after reset must carry no stale bits.
        pat = 8'hA4;
        sb_q.push_back('{y: 8'hA4, mask: 8'hFF});
        for (int i = 0; i < 8; i++) begin
            write(4'(2 * i), pat[i]);
        end
        in_valid = 1'b0;
        drain("post_rst");

`ifdef DEMUX_PACK_TIMEOUT_EN
        // Partial word released after FLUSH_TIMEOUT idle cycles.
        write(4'd6, 1'b1);
        in_valid = 1'b0;
        sb_q.push_back('{y: 8'h08, mask: 8'h08});
        for (int i = 1; i <= FLUSH_TIMEOUT; i++) begin
            tick();
            check($sformatf("to_ov_%0d", i), {7'd0, out_valid},
                  (i == FLUSH_TIMEOUT) ? 8'h01 : 8'h00);
        end
        drain("timeout");
        // An empty word never times out.
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen |= out_valid;
        end
        check("to_empty_no_release", {7'd0, seen}, 8'h00);
`else
        // Without the timeout a partial word is never released.
        write(4'd6, 1'b1);
        in_valid = 1'b0;
        check("nto_mask", lane_mask, 8'h08);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen |= out_valid;
        end
        check("nto_no_release", {7'd0, seen}, 8'h00);
        check("nto_Y_kept", Y, 8'h08);
`endif

        check("sb_drained", 8'(sb_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
